// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the ID-stage hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StFlushJ = 2'd2
  } state_e;

  localparam int unsigned LuStallDef = 1;
  localparam int unsigned JrStallDef = 2;
  localparam int unsigned StallCntW  = 8;
  localparam logic [4:0]  RegZero    = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Pure comparators flagging load-use and jr-operand hazards for the instruction in ID.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       id_jr_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] ex_write_reg_i,
  input  logic       mem_mem_read_i,
  input  logic [4:0] mem_write_reg_i,
  output logic       lu_o,
  output logic       jr_alu_o,
  output logic       jr_load_o
);

  logic ex_dest_valid, mem_dest_valid;

  always_comb begin
    ex_dest_valid  = (ex_write_reg_i != RegZero);
    mem_dest_valid = (mem_write_reg_i != RegZero);

    lu_o      = ex_mem_read_i & ex_dest_valid &
                ((ex_write_reg_i == id_rs_i) | (id_uses_rt_i & (ex_write_reg_i == id_rt_i)));
    // A load in EX is already covered by lu; jr_alu only covers ALU producers.
    jr_alu_o  = id_jr_i & ex_reg_write_i & ~ex_mem_read_i & ex_dest_valid &
                (ex_write_reg_i == id_rs_i);
    jr_load_o = id_jr_i & mem_mem_read_i & mem_dest_valid & (mem_write_reg_i == id_rs_i);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller beside the ID decoder: stall FSM with bubble down-counter,
// branch/jump flushes and saturating stall/flush performance counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LU_STALL = LuStallDef,
  parameter int unsigned JR_STALL = JrStallDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jr,
  input  logic             ID_Jump,
  input  logic             ID_Jal,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [StallCntW-1:0] LuLen  = StallCntW'(LU_STALL - 1);
  localparam logic [StallCntW-1:0] JrLen  = StallCntW'(JR_STALL - 1);
  localparam logic [StallCntW-1:0] CntOne = StallCntW'(1);

  state_e               state_q, state_d;
  logic [StallCntW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                 lu, jr_alu, jr_load, hazard;

  hazard_detect u_detect (
    .id_rs_i        (ID_Rs),
    .id_rt_i        (ID_Rt),
    .id_uses_rt_i   (ID_UsesRt),
    .id_jr_i        (ID_Jr),
    .ex_mem_read_i  (EX_MemRead),
    .ex_reg_write_i (EX_RegWrite),
    .ex_write_reg_i (EX_WriteReg),
    .mem_mem_read_i (MEM_MemRead),
    .mem_write_reg_i(MEM_WriteReg),
    .lu_o           (lu),
    .jr_alu_o       (jr_alu),
    .jr_load_o      (jr_load)
  );

  assign hazard = lu | jr_alu | jr_load;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;

    case (state_q)
      StStall: begin
        if (EX_BranchTaken) begin
          // Taken branch squashes the stalled instruction, so the bubble train is moot.
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          cnt_d      = '0;
          state_d    = StRun;
        end else begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
          cnt_d      = cnt_q - CntOne;
          if (cnt_q <= CntOne) state_d = StRun;
        end
      end
      default: begin
        // StFlushJ is never entered and behaves exactly like StRun.
        state_d = StRun;
        if (EX_BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (hazard) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
          cnt_d      = jr_alu ? JrLen : LuLen;
          state_d    = (cnt_d != '0) ? StStall : StRun;
        end else if (ID_Jump | ID_Jal | ID_Jr) begin
          IFID_Flush = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((IFID_Flush | IDEX_Flush) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  localparam int unsigned CntW = 4;
  localparam int          Sat  = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic            ID_UsesRt, ID_Jr, ID_Jump, ID_Jal;
  logic            EX_MemRead, EX_RegWrite, MEM_MemRead, EX_BranchTaken;
  logic            PCWrite, IFID_Write, IFID_Flush, IDEX_Flush;
  logic [CntW-1:0] StallCount, FlushCount;

  int checks   = 0;
  int failures = 0;

  // Model state: remaining stall cycles after the current one, and counter values.
  int         m_left  = 0;
  int         m_stall = 0;
  int         m_flush = 0;
  logic       m_haz, m_jra;
  logic [3:0] exp_ctrl;
  logic [3:0] ctrl;

  assign ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush};

  hazard_stall_unit #(.CNT_W(CntW), .LU_STALL(1), .JR_STALL(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .ID_Jr         (ID_Jr),
    .ID_Jump       (ID_Jump),
    .ID_Jal        (ID_Jal),
    .EX_MemRead    (EX_MemRead),
    .EX_RegWrite   (EX_RegWrite),
    .EX_WriteReg   (EX_WriteReg),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_WriteReg  (MEM_WriteReg),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite       (PCWrite),
    .IFID_Write    (IFID_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Flush    (IDEX_Flush),
    .StallCount    (StallCount),
    .FlushCount    (FlushCount)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    logic lu, jrl;
    lu    = EX_MemRead && (EX_WriteReg != 0) &&
            ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    m_jra = ID_Jr && EX_RegWrite && !EX_MemRead && (EX_WriteReg != 0) && (EX_WriteReg == ID_Rs);
    jrl   = ID_Jr && MEM_MemRead && (MEM_WriteReg != 0) && (MEM_WriteReg == ID_Rs);
    m_haz = lu || m_jra || jrl;
    if (m_left > 0)                    exp_ctrl = EX_BranchTaken ? 4'b1111 : 4'b0001;
    else if (EX_BranchTaken)           exp_ctrl = 4'b1111;
    else if (m_haz)                    exp_ctrl = 4'b0001;
    else if (ID_Jump || ID_Jal || ID_Jr) exp_ctrl = 4'b1110;
    else                               exp_ctrl = 4'b1100;
  endtask

  task automatic model_commit();
    model_eval();
    if (reset) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_ctrl[3] && m_stall < Sat) m_stall++;
      if ((exp_ctrl[1] || exp_ctrl[0]) && m_flush < Sat) m_flush++;
      if (m_left > 0)                        m_left = EX_BranchTaken ? 0 : m_left - 1;
      else if (!EX_BranchTaken && m_haz)     m_left = (m_jra ? 2 : 1) - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_Jr = 0; ID_Jump = 0; ID_Jal = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    MEM_MemRead = 0; MEM_WriteReg = 0; EX_BranchTaken = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
  endtask

  task automatic set_jr_alu();
    clear_inputs();
    ID_Jr = 1; ID_Rs = 31; EX_RegWrite = 1; EX_WriteReg = 31;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ID_Rs = 5'($urandom); ID_Rt = 5'($urandom); ID_UsesRt = 1'($urandom);
    EX_MemRead = 1; EX_WriteReg = ID_Rs;
    tick();
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctrl !== 4'b1100) begin
      failures++; $display("FAIL reset_ctrl: got %b exp %b", ctrl, 4'b1100);
    end
    checks++;
    if (StallCount !== 0 || FlushCount !== 0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", StallCount, FlushCount);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 8; ID_Rs = 8; ID_Rt = 9; ID_UsesRt = 1;
    #1;
    checks++;
    if (ctrl !== 4'b0001) begin
      failures++; $display("FAIL lu_stall: got %b exp %b", ctrl, 4'b0001);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ctrl !== 4'b1100 || StallCount !== 1) begin
      failures++; $display("FAIL lu_release: got %b cnt=%0d exp 1100 cnt=1", ctrl, StallCount);
    end
    EX_MemRead = 1; EX_WriteReg = 8; ID_Rs = 3; ID_Rt = 8; ID_UsesRt = 0;
    #1;
    checks++;
    if (ctrl !== 4'b1100) begin
      failures++; $display("FAIL lu_rt_unused: got %b exp %b", ctrl, 4'b1100);
    end
    EX_WriteReg = 0; ID_Rs = 0; ID_UsesRt = 1;
    #1;
    checks++;
    if (ctrl !== 4'b1100) begin
      failures++; $display("FAIL lu_reg_zero: got %b exp %b", ctrl, 4'b1100);
    end
    tick();
  endtask

  task automatic test_jr_alu();
    do_reset();
    set_jr_alu();
    #1;
    checks++;
    if (ctrl !== 4'b0001) begin
      failures++; $display("FAIL jr_stall1: got %b exp %b", ctrl, 4'b0001);
    end
    tick();
    checks++;
    if (ctrl !== 4'b0001) begin
      failures++; $display("FAIL jr_stall2: got %b exp %b", ctrl, 4'b0001);
    end
    tick();
    EX_RegWrite = 0;
    #1;
    checks++;
    if (ctrl !== 4'b1110) begin
      failures++; $display("FAIL jr_flush: got %b exp %b", ctrl, 4'b1110);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (StallCount !== 2 || FlushCount !== 3) begin
      failures++; $display("FAIL jr_counts: got %0d/%0d exp 2/3", StallCount, FlushCount);
    end
  endtask

  task automatic test_branch_abort();
    do_reset();
    set_jr_alu();
    tick();
    EX_BranchTaken = 1;
    #1;
    checks++;
    if (ctrl[1:0] !== 2'b11) begin
      failures++; $display("FAIL abort_flush: got %b exp 11", ctrl[1:0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ctrl !== 4'b1100) begin
      failures++; $display("FAIL abort_run: got %b exp %b", ctrl, 4'b1100);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_jr_alu();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctrl !== 4'b1100 || StallCount !== 0 || FlushCount !== 0) begin
      failures++;
      $display("FAIL reset_mid_stall: got %b %0d/%0d exp 1100 0/0", ctrl, StallCount, FlushCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      EX_MemRead = 1; EX_WriteReg = 5; ID_Rs = 5;
      tick();
      clear_inputs();
      tick();
    end
    checks++;
    if (StallCount !== 4'd15 || FlushCount !== 4'd15) begin
      failures++; $display("FAIL saturate: got %0d/%0d exp 15/15", StallCount, FlushCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      ID_UsesRt      = 1'($urandom);
      ID_Jr          = ($urandom_range(0, 3) == 0);
      ID_Jump        = ($urandom_range(0, 7) == 0);
      ID_Jal         = ($urandom_range(0, 7) == 0);
      EX_MemRead     = ($urandom_range(0, 2) == 0);
      EX_RegWrite    = 1'($urandom);
      EX_WriteReg    = 5'($urandom_range(0, 3));
      MEM_MemRead    = ($urandom_range(0, 2) == 0);
      MEM_WriteReg   = 5'($urandom_range(0, 3));
      EX_BranchTaken = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      checks++;
      if (ctrl !== exp_ctrl) begin
        failures++; $display("FAIL rand_ctrl[%0d]: got %b exp %b", i, ctrl, exp_ctrl);
      end
      checks++;
      if (StallCount !== CntW'(m_stall) || FlushCount !== CntW'(m_flush)) begin
        failures++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d exp %0d/%0d",
                 i, StallCount, FlushCount, m_stall, m_flush);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_jr_alu();
    test_branch_abort();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
